// File: rtl/mat_addr_gen_if.sv
// Operand/result address stream bundle between mat_addr_gen and the MAC datapath.
// master drives the beat (valid, addresses, first/last flags); slave returns ready.
interface mat_addr_gen_if #(
  parameter int ADDR_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_c;
  logic              first_k;
  logic              last_k;

  modport master (
    output out_valid, addr_a, addr_b, addr_c, first_k, last_k,
    input  out_ready
  );

  modport slave (
    input  out_valid, addr_a, addr_b, addr_c, first_k, last_k,
    output out_ready
  );
endinterface

// File: rtl/mat_addr_gen.sv
// mat_addr_gen: operand address generator for C = A x B (row-major A MxK, B KxN, C MxN).
// Emits one A/B address pair per MAC beat (i outer, j middle, k inner) and a C write
// address flagged by last_k. Addresses are built incrementally (no multipliers) and wrap
// modulo 2^ADDR_W.
// Optional build macro MAT_TRANSPOSE_B_EN: adds trans_b, selecting B stored N x K row-major.
module mat_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
`ifdef MAT_TRANSPOSE_B_EN
  input  logic              trans_b,
`endif
  output logic              busy,
  output logic              done,
  mat_addr_gen_if.master    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, kc_q, kc_d;
  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;     // current A address
  logic [ADDR_W-1:0] a_row_q, a_row_d;     // A address of k=0 in the current row i
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;     // current B address
  logic [ADDR_W-1:0] b_col_q, b_col_d;     // B address of k=0 in column j (non-transposed)
  logic [ADDR_W-1:0] b_base_q, b_base_d;   // latched base_b, reloaded on every j wrap
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;     // C address of the current dot product
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trans_s;

  logic              last_i_s, last_j_s, last_k_s;
  logic              any_zero_s;
  logic [ADDR_W-1:0] b_step_s;             // B stride along k

`ifdef MAT_TRANSPOSE_B_EN
  logic trans_q, trans_d;

  // Transpose-mode selector register, captured at launch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      trans_q <= 1'b0;
    end else begin
      trans_q <= trans_d;
    end
  end

  // Capture trans_b only when a launch is accepted.
  always_comb begin
    trans_d = trans_q;
    if ((state_q == ST_IDLE) && start) begin
      trans_d = trans_b;
    end else begin
      trans_d = trans_q;
    end
  end

  assign trans_s = trans_q;
`else
  assign trans_s = 1'b0;
`endif

  assign last_i_s   = (i_q  == (m_q - DIM_W'(1)));
  assign last_j_s   = (j_q  == (n_q - DIM_W'(1)));
  assign last_k_s   = (kc_q == (k_q - DIM_W'(1)));
  assign any_zero_s = (dim_m == DIM_W'(0)) || (dim_n == DIM_W'(0)) || (dim_k == DIM_W'(0));
  assign b_step_s   = trans_s ? ADDR_W'(1) : ADDR_W'(n_q);

  // State and beat registers; reset clears everything, even mid-run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      kc_q     <= '0;
      a_ptr_q  <= '0;
      a_row_q  <= '0;
      b_ptr_q  <= '0;
      b_col_q  <= '0;
      b_base_q <= '0;
      c_ptr_q  <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kc_q     <= kc_d;
      a_ptr_q  <= a_ptr_d;
      a_row_q  <= a_row_d;
      b_ptr_q  <= b_ptr_d;
      b_col_q  <= b_col_d;
      b_base_q <= b_base_d;
      c_ptr_q  <= c_ptr_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state and next beat: launch, advance on each accepted beat, hold on stall.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    kc_d     = kc_q;
    a_ptr_d  = a_ptr_q;
    a_row_d  = a_row_q;
    b_ptr_d  = b_ptr_q;
    b_col_d  = b_col_q;
    b_base_d = b_base_q;
    c_ptr_d  = c_ptr_q;
    valid_d  = valid_q;
    first_d  = first_q;
    last_d   = last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d      = dim_m;
          n_d      = dim_n;
          k_d      = dim_k;
          i_d      = '0;
          j_d      = '0;
          kc_d     = '0;
          a_ptr_d  = base_a;
          a_row_d  = base_a;
          b_ptr_d  = base_b;
          b_col_d  = base_b;
          b_base_d = base_b;
          c_ptr_d  = base_c;
          if (any_zero_s) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = (dim_k == DIM_W'(1));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (valid_q && bus.out_ready) begin
          if (last_i_s && last_j_s && last_k_s) begin
            // Final beat accepted: stream ends.
            state_d = ST_DONE;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else if (!last_k_s) begin
            // Step along k within the dot product.
            kc_d    = kc_q + DIM_W'(1);
            a_ptr_d = a_ptr_q + ADDR_W'(1);
            b_ptr_d = b_ptr_q + b_step_s;
            first_d = 1'b0;
            last_d  = ((kc_q + DIM_W'(2)) == k_q);
          end else begin
            // Dot product finished: next C element.
            kc_d    = '0;
            c_ptr_d = c_ptr_q + ADDR_W'(1);
            first_d = 1'b1;
            last_d  = (k_q == DIM_W'(1));
            if (!last_j_s) begin
              j_d     = j_q + DIM_W'(1);
              a_ptr_d = a_row_q;
              b_col_d = b_col_q + ADDR_W'(1);
              // Transposed B rows are contiguous, so the pointer just keeps counting.
              b_ptr_d = trans_s ? (b_ptr_q + ADDR_W'(1)) : (b_col_q + ADDR_W'(1));
            end else begin
              j_d     = '0;
              i_d     = i_q + DIM_W'(1);
              a_row_d = a_row_q + ADDR_W'(k_q);
              a_ptr_d = a_row_q + ADDR_W'(k_q);
              b_col_d = b_base_q;
              b_ptr_d = b_base_q;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign bus.out_valid = valid_q;
  assign bus.addr_a    = a_ptr_q;
  assign bus.addr_b    = b_ptr_q;
  assign bus.addr_c    = c_ptr_q;
  assign bus.first_k   = first_q;
  assign bus.last_k    = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mat_addr_gen.sv
// Self-checking bench for mat_addr_gen: directed scenarios plus randomized runs with
// random backpressure, compared against a loop-nest reference of the address formulas.
module tb_mat_addr_gen;
  localparam int ADDR_W = 8;
  localparam int DIM_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  dim_m, dim_n, dim_k;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic              busy, done;
`ifdef MAT_TRANSPOSE_B_EN
  logic              trans_b;
`endif

  always #5 clk = ~clk;

  mat_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

  mat_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dim_m  (dim_m),
    .dim_n  (dim_n),
    .dim_k  (dim_k),
    .base_a (base_a),
    .base_b (base_b),
    .base_c (base_c),
`ifdef MAT_TRANSPOSE_B_EN
    .trans_b(trans_b),
`endif
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected beats: {addr_a, addr_b, addr_c (only when last), first_k, last_k}
  logic [25:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: straight loop nest over the address formulas.
  task automatic build_model(input int m, input int n, input int k,
                             input int ba, input int bb, input int bc, input bit tr);
    logic [7:0] a, b, c;
    bit f, l;
    exp_q.delete();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          a = 8'(ba + i * k + kk);
          b = tr ? 8'(bb + j * k + kk) : 8'(bb + kk * n + j);
          f = (kk == 0);
          l = (kk == k - 1);
          c = l ? 8'(bc + i * n + j) : 8'h00;
          exp_q.push_back({a, b, c, f, l});
        end
  endtask

  function automatic logic [25:0] observed_beat();
    return {bus.addr_a, bus.addr_b, (bus.last_k ? bus.addr_c : 8'h00), bus.first_k, bus.last_k};
  endfunction

  // One operation; called and returning on a negedge with the DUT idle.
  task automatic run_op(input int m, input int n, input int k,
                        input int ba, input int bb, input int bc, input bit tr,
                        input int pct, input int stall_at, input int rst_at);
    int  sent;
    int  cyc;
    int  stall_left;
    bit  rdy;
    sent = 0;
    cyc = 0;
    stall_left = 3;
    build_model(m, n, k, ba, bb, bc, tr);
    dim_m  = 4'(m);
    dim_n  = 4'(n);
    dim_k  = 4'(k);
    base_a = 8'(ba);
    base_b = 8'(bb);
    base_c = 8'(bc);
`ifdef MAT_TRANSPOSE_B_EN
    trans_b = tr;
`endif
    start = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    // Latched inputs are don't-care from here on.
    dim_m  = 4'($urandom);
    dim_n  = 4'($urandom);
    dim_k  = 4'($urandom);
    base_a = 8'($urandom);
    base_b = 8'($urandom);
    base_c = 8'($urandom);
`ifdef MAT_TRANSPOSE_B_EN
    trans_b = 1'($urandom);
`endif
    if (exp_q.size() == 0) begin
      start = 1'b0;
      check_val("zero_dim_done", 32'(done), 32'd1);
      check_val("zero_dim_valid", 32'(bus.out_valid), 32'd0);
      check_val("zero_dim_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check_val("zero_dim_done_clr", 32'(done), 32'd0);
      check_val("zero_dim_idle_valid", 32'(bus.out_valid), 32'd0);
      return;
    end
    while (exp_q.size() > 0 && cyc < 3000) begin
      start = 1'($urandom);   // must be ignored outside IDLE
      check_val("run_valid", 32'(bus.out_valid), 32'd1);
      check_val("run_busy", 32'(busy), 32'd1);
      check_val("run_done", 32'(done), 32'd0);
      check_val($sformatf("beat%0d", sent), 32'(observed_beat()), 32'(exp_q[0]));
      if (sent == rst_at) begin
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_addr", 32'({bus.addr_a, bus.addr_b, bus.addr_c}), 32'd0);
        check_val("rst_flags", 32'({bus.first_k, bus.last_k}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_idle_done", 32'(done), 32'd0);
        exp_q.delete();
        return;
      end
      if (sent == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) < pct);
      end
      bus.out_ready = rdy;
      if (rdy) begin
        void'(exp_q.pop_front());
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_val("beats_left", 32'(exp_q.size()), 32'd0);
    check_val("end_valid", 32'(bus.out_valid), 32'd0);
    check_val("end_busy", 32'(busy), 32'd0);
    check_val("end_done", 32'(done), 32'd1);
    @(negedge clk);
    check_val("end_done_clr", 32'(done), 32'd0);
    check_val("end_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int m, n, k;
    bit tr;
    rst = 1'b0;
    start = 1'b0;
    dim_m = '0;
    dim_n = '0;
    dim_k = '0;
    base_a = '0;
    base_b = '0;
    base_c = '0;
`ifdef MAT_TRANSPOSE_B_EN
    trans_b = 1'b0;
`endif
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_valid", 32'(bus.out_valid), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_addr", 32'({bus.addr_a, bus.addr_b, bus.addr_c}), 32'd0);
    check_val("reset_flags", 32'({bus.first_k, bus.last_k}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 2x2x2 streaming
    run_op(2, 2, 2, 0, 16, 32, 1'b0, 100, -1, -1);
    // same run, beat 3 held for three cycles
    run_op(2, 2, 2, 0, 16, 32, 1'b0, 100, 2, -1);
    // zero inner dimension: no beats
    run_op(2, 2, 0, 0, 16, 32, 1'b0, 100, -1, -1);
    // address wrap
    run_op(1, 1, 4, 254, 0, 77, 1'b0, 100, -1, -1);
    // K=1: every beat both first and last
    run_op(2, 3, 1, 10, 40, 200, 1'b0, 100, -1, -1);
    // reset during beat 5, then a fresh full run
    run_op(2, 2, 2, 0, 16, 32, 1'b0, 100, -1, 4);
    run_op(2, 2, 2, 0, 16, 32, 1'b0, 100, -1, -1);
`ifdef MAT_TRANSPOSE_B_EN
    run_op(2, 2, 2, 0, 16, 32, 1'b1, 100, -1, -1);
`endif

    // randomized runs with random backpressure
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, 4);
      n = $urandom_range(0, 4);
      k = $urandom_range(0, 5);
`ifdef MAT_TRANSPOSE_B_EN
      tr = 1'($urandom);
`else
      tr = 1'b0;
`endif
      run_op(m, n, k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), tr, int'($urandom_range(30, 100)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
